symb_detect: RTL
================

# symb_detect

Receive-side counterpart of the symbol LUT transmitter. It deserialises the 128-chip real/imaginary chip streams, stores one complete symbol, and scans the 32-entry symbol table through an external read port. It outputs the 5-bit symbol index whose stored sequence has the highest chip agreement with the received one. It sits after chip slicing/timing recovery and feeds the demapped symbol to the downstream bit unpacker.

## Interface
Parameters:
- ERASE_THRESH, 192: minimum total agreement score for a non-erased decision (used only under SYMB_DETECT_ERASURE_EN).

Ports:
- CLOCK  input  1  single system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- SYNC  input  1  marks the cycle of chip 0 of a symbol; restarts chip counting.
- DINVALID  input  1  chip strobe; DINREAL/DINIMAG are sampled only when high.
- DINREAL  input  1  real-rail chip.
- DINIMAG  input  1  imaginary-rail chip.
- LUTADDR  output  5  symbol table read address.
- LUTREAL  input  128  real sequence for LUTADDR, valid one cycle after the address (registered ROM).
- LUTIMAG  input  128  imaginary sequence, same timing as LUTREAL.
- DOUT  output  5  decided symbol index, held until the next decision.
- SCORE  output  9  best agreement score (0..256), held with DOUT.
- DVALID  output  1  one-cycle pulse when DOUT/SCORE/DERR update.
- DERR  output  1  erasure flag, qualified by DVALID.
- BUSY  output  1  high while the table search runs.

## Operation
- Chip order matches the transmitter: the first chip sent is sequence bit 127.
- Capture side: two 128-bit shift registers, updated as {buf[126:0], DIN} on each DINVALID; a 7-bit chip counter.
- Capture states:
  - HUNT: after reset, chips are ignored until SYNC.
  - COLLECT: counts chips 0..127.
- SYNC with DINVALID in the same cycle: that chip is chip 0.
- SYNC mid-collection: discard the partial symbol and set the counter to 0 (SYNC without DINVALID leaves the counter at 0).
- Chip 127 captured:
  - copy both capture registers to the compare registers;
  - start the search;
  - counter wraps to 0 and collection of the next symbol continues without a new SYNC.
- Search FSM states:
  - IDLE → SEARCH (on capture complete).
  - SEARCH issues LUTADDR 0..31, one per cycle, then 1 drain cycle.
  - SEARCH → DONE → IDLE.
- Score per entry: popcount(~(cmpREAL ^ LUTREAL)) + popcount(~(cmpIMAG ^ LUTIMAG)), 9-bit unsigned.
- Best entry tracking: updates only on strictly greater score, so ties keep the lowest index. The running best is initialised by entry 0.
- DONE: load DOUT and SCORE, evaluate DERR, pulse DVALID.
- Search length (34 cycles) is shorter than the minimum symbol period (128 cycles), so a search never overlaps the next capture-complete. The FSM needs no back-pressure.
- LUTADDR returns to 0 when not searching.

## Timing
- Reset values:
  - DOUT=0, SCORE=0, DVALID=0, DERR=0, BUSY=0, LUTADDR=0;
  - counters, buffers and best-tracking = 0;
  - capture state HUNT, search state IDLE.
- Last chip sampled in cycle T.
- T+1: compare registers valid, BUSY=1, LUTADDR=0.
- LUTADDR=k in cycle T+1+k; LUT data for k is present in T+2+k; best is updated at the end of T+2+k.
- T+34: DVALID=1, DOUT/SCORE/DERR valid, BUSY=0. Latency from the last chip to DVALID is 34 cycles.
- RESET in any cycle (including mid-SEARCH): return to reset values next cycle; no DVALID for an aborted search.
- SYNC during SEARCH: affects only capture; the running search completes normally.

## Configuration
- SYMB_DETECT_ERASURE_EN defined: DERR=1 with DVALID when best SCORE < ERASE_THRESH; DOUT still carries the best index.
- Not defined: DERR is tied to 0 and the comparison logic is omitted. Port list is unchanged.

## Test plan
- Clean symbol: SYNC, then the 128 chips of entry 5 on both rails (ROM model = transmitter table) → DVALID 34 cycles after the last chip, DOUT=5, SCORE=256, DERR=0.
- Noise: entry 17 with 20 real chips inverted → DOUT=17, SCORE=236.
- Tie: ROM model with entries 3 and 7 identical, send entry 3 → DOUT=3.
- Back-to-back: one SYNC, then entries 0 and 31 continuously at one chip per cycle → two DVALID pulses 128 cycles apart, DOUT=0 then 31.
- Resync/reset:
  - 60 chips of garbage, SYNC, then entry 9 → exactly one DVALID, DOUT=9.
  - RESET at T+10 of a search → no DVALID, all outputs 0.
- Erasure (SYMB_DETECT_ERASURE_EN, ERASE_THRESH=192): entry 12 with 80 chips inverted across both rails → DVALID with DERR=1. Without the macro → DERR=0.

Source files
------------

// File: rtl/symb_detect.sv
// rtl/symb_detect.sv - chip deserialiser and best-match search over a 32-entry symbol table.
// Optional erasure flagging is compiled in with SYMB_DETECT_ERASURE_EN.
module symb_detect
`ifdef SYMB_DETECT_ERASURE_EN
  #(parameter int unsigned ERASE_THRESH = 192)
`endif
(
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         SYNC,
  input  logic         DINVALID,
  input  logic         DINREAL,
  input  logic         DINIMAG,
  output logic [4:0]   LUTADDR,
  input  logic [127:0] LUTREAL,
  input  logic [127:0] LUTIMAG,
  output logic [4:0]   DOUT,
  output logic [8:0]   SCORE,
  output logic         DVALID,
  output logic         DERR,
  output logic         BUSY
);

  localparam logic [0:0] CAP_HUNT    = 1'b0;
  localparam logic [0:0] CAP_COLLECT = 1'b1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [0:0]   cap_state_q, cap_state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [127:0] buf_re_q, buf_re_d, buf_im_q, buf_im_d;
  logic [127:0] cmp_re_q, cmp_re_d, cmp_im_q, cmp_im_d;
  logic         cap_done;

  logic [1:0]   srch_q, srch_d;
  logic [5:0]   ph_q, ph_d;
  logic [8:0]   best_score_q, best_score_d;
  logic [4:0]   best_idx_q, best_idx_d;
  logic [4:0]   dout_q, dout_d;
  logic [8:0]   score_q, score_d;
  logic         dvalid_q, dvalid_d;
  logic         derr_q, derr_d;
  logic [8:0]   score;
  logic [4:0]   entry;

  // Capture: SYNC both arms collection and restarts the chip count.
  always_comb begin
    cap_state_d = cap_state_q;
    cnt_d       = cnt_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    cmp_re_d    = cmp_re_q;
    cmp_im_d    = cmp_im_q;
    cap_done    = 1'b0;
    if (SYNC) begin
      cap_state_d = CAP_COLLECT;
      cnt_d       = 7'd0;
    end
    if ((SYNC || cap_state_q == CAP_COLLECT) && DINVALID) begin
      buf_re_d = {buf_re_q[126:0], DINREAL};
      buf_im_d = {buf_im_q[126:0], DINIMAG};
      if (SYNC) begin
        cnt_d = 7'd1;
      end else begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd127) begin
          cap_done = 1'b1;
          cmp_re_d = buf_re_d;
          cmp_im_d = buf_im_d;
        end
      end
    end
  end

  assign score = 9'($countones(~(cmp_re_q ^ LUTREAL))) + 9'($countones(~(cmp_im_q ^ LUTIMAG)));
  // ROM data lags the address by one cycle, so phase p carries entry p-1.
  assign entry = ph_q[4:0] - 5'd1;

  always_comb begin
    srch_d       = srch_q;
    ph_d         = ph_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    dout_d       = dout_q;
    score_d      = score_q;
    dvalid_d     = 1'b0;
    derr_d       = derr_q;
    case (srch_q)
      S_IDLE: begin
        ph_d = 6'd0;
        if (cap_done) srch_d = S_SEARCH;
      end
      S_SEARCH: begin
        ph_d = ph_q + 6'd1;
        if (ph_q != 6'd0 && (ph_q == 6'd1 || score > best_score_q)) begin
          best_score_d = score;
          best_idx_d   = entry;
        end
        if (ph_q == 6'd32) begin
          srch_d   = S_DONE;
          dout_d   = best_idx_d;
          score_d  = best_score_d;
          dvalid_d = 1'b1;
`ifdef SYMB_DETECT_ERASURE_EN
          derr_d   = 32'(best_score_d) < ERASE_THRESH;
`else
          derr_d   = 1'b0;
`endif
        end
      end
      default: begin
        srch_d = S_IDLE;
        ph_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cap_state_q  <= CAP_HUNT;
      cnt_q        <= '0;
      buf_re_q     <= '0;
      buf_im_q     <= '0;
      cmp_re_q     <= '0;
      cmp_im_q     <= '0;
      srch_q       <= S_IDLE;
      ph_q         <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      dout_q       <= '0;
      score_q      <= '0;
      dvalid_q     <= 1'b0;
      derr_q       <= 1'b0;
    end else begin
      cap_state_q  <= cap_state_d;
      cnt_q        <= cnt_d;
      buf_re_q     <= buf_re_d;
      buf_im_q     <= buf_im_d;
      cmp_re_q     <= cmp_re_d;
      cmp_im_q     <= cmp_im_d;
      srch_q       <= srch_d;
      ph_q         <= ph_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      dout_q       <= dout_d;
      score_q      <= score_d;
      dvalid_q     <= dvalid_d;
      derr_q       <= derr_d;
    end
  end

  assign LUTADDR = (srch_q == S_SEARCH && !ph_q[5]) ? ph_q[4:0] : 5'd0;
  assign BUSY    = (srch_q == S_SEARCH);
  assign DOUT    = dout_q;
  assign SCORE   = score_q;
  assign DVALID  = dvalid_q;
  assign DERR    = derr_q;

endmodule
